// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied when the last iteration retires.
module muldiv_iter #(
    parameter int unsigned XLEN        = 32,
    parameter bit          FAST_MUL_EN = 1'b0,
    parameter bit          DIVIDER_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned W2 = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [2:0]      op_q;
    logic            sa_q, sb_q;
    logic [W2-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] rem_q, quo_q, divisor_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic [XLEN-1:0] result_q;

    logic            a_signed, b_signed, sa_d, sb_d;
    logic [XLEN-1:0] ma_d, mb_d;
    logic            short_d;
    logic [XLEN-1:0] short_res_d;
    logic [W2-1:0]   fast_prod, fast_signed;

    logic [W2-1:0]   acc_d, prod_fin;
    logic [XLEN:0]   rem_sh, rem_diff;
    logic [XLEN-1:0] rem_d, quo_d, fin_res;

    function automatic logic [XLEN-1:0] mul_sel(input logic [2:0] f, input logic [W2-1:0] p);
        return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[W2-1:XLEN];
    endfunction

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        sa_d = a_signed & a[XLEN-1];
        sb_d = b_signed & b[XLEN-1];
        ma_d = sa_d ? -a : a;
        mb_d = sb_d ? -b : b;
    end

    // Ops that resolve at the accept edge and bypass RUN entirely.
    always_comb begin
        short_d     = 1'b0;
        short_res_d = '0;
        fast_prod   = {{XLEN{1'b0}}, ma_d} * {{XLEN{1'b0}}, mb_d};
        fast_signed = (sa_d ^ sb_d) ? -fast_prod : fast_prod;
        if (op[2]) begin
            if (!DIVIDER_EN) begin
                short_d     = 1'b1;
                short_res_d = '0;
            end else if (b == '0) begin
                short_d     = 1'b1;
                short_res_d = op[1] ? a : '1;
            end else if (!op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
                short_d     = 1'b1;
                short_res_d = op[1] ? '0 : a;
            end
        end else if (FAST_MUL_EN) begin
            short_d     = 1'b1;
            short_res_d = mul_sel(op, fast_signed);
        end
    end

    always_comb begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, divisor_q};
        quo_d    = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
        rem_d    = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
        prod_fin = (sa_q ^ sb_q) ? -acc_d : acc_d;
        case (op_q)
            3'b100, 3'b101: fin_res = (sa_q ^ sb_q) ? -quo_d : quo_d;
            3'b110, 3'b111: fin_res = sa_q ? -rem_d : rem_d;
            default:        fin_res = mul_sel(op_q, prod_fin);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    cnt_q    <= cnt_q + CW'(1);
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    rem_q    <= rem_d;
                    quo_q    <= quo_d;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= fin_res;
                    end
                end
                default: begin
                    if (start) begin
                        op_q      <= op;
                        sa_q      <= sa_d;
                        sb_q      <= sb_d;
                        acc_q     <= '0;
                        mcand_q   <= {{XLEN{1'b0}}, ma_d};
                        mplier_q  <= mb_d;
                        rem_q     <= '0;
                        quo_q     <= ma_d;
                        divisor_q <= mb_d;
                        cnt_q     <= '0;
                        if (short_d) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= short_res_d;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized scoreboard bench for muldiv_iter plus latency/result checks on the
// fast-multiply and divider-less builds.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        f_start, f_busy, f_done;
    logic [2:0]  f_op;
    logic [31:0] f_a, f_b, f_result;
    logic        n_start, n_busy, n_done;
    logic [2:0]  n_op;
    logic [31:0] n_a, n_b, n_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] last_result = '0;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        bit          short_op;
    } exp_t;
    exp_t scb[$];

    muldiv_iter #(.XLEN(32), .FAST_MUL_EN(1'b0), .DIVIDER_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    muldiv_iter #(.XLEN(32), .FAST_MUL_EN(1'b1), .DIVIDER_EN(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(f_start), .op(f_op), .a(f_a), .b(f_b),
        .busy(f_busy), .done(f_done), .result(f_result)
    );

    muldiv_iter #(.XLEN(32), .FAST_MUL_EN(1'b0), .DIVIDER_EN(1'b0)) u_nodiv (
        .clk(clk), .rst_n(rst_n), .start(n_start), .op(n_op), .a(n_a), .b(n_b),
        .busy(n_busy), .done(n_done), .result(n_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        p  = 0;
        r  = '0;
        case (f)
            3'd0: begin p = sx * sy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4: begin if (y == 0) r = '1; else begin p = sx / sy; r = p[31:0]; end end
            3'd5: begin if (y == 0) r = '1; else begin p = ux / uy; r = p[31:0]; end end
            3'd6: begin if (y == 0) r = x;  else begin p = sx % sy; r = p[31:0]; end end
            default: begin if (y == 0) r = x; else begin p = ux % uy; r = p[31:0]; end end
        endcase
        return r;
    endfunction

    function automatic bit is_short(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares against the scoreboard one sample after each rising edge.
    always begin
        bit exp_busy;
        @(posedge clk);
        #1;
        exp_busy = (scb.size() != 0) && !scb[0].short_op && (cyc < scb[0].done_cyc);
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (done) begin
            if (scb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got=1 expected=0 cycle=%0d result=%h", cyc, result);
            end else begin
                chk("done_cycle", 32'(cyc), 32'(scb[0].done_cyc));
                chk("result", result, scb[0].res);
                last_result = scb[0].res;
                void'(scb.pop_front());
            end
        end else begin
            chk("result_hold", result, last_result);
            if (scb.size() != 0 && cyc >= scb[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done got=0 expected=1 cycle=%0d", cyc);
                void'(scb.pop_front());
            end
        end
    end

    task automatic scramble();
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called at a falling edge; drives one request cycle and records it if the unit can accept.
    task automatic req(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        start = 1'b1;
        op    = f;
        a     = x;
        b     = y;
        if (rst_n && scb.size() == 0) begin
            e.res      = model(f, x, y);
            e.short_op = is_short(f, x, y);
            e.done_cyc = cyc + (e.short_op ? 1 : 33);
            scb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drop(input int n);
        scramble();
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        scramble();
        while (scb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy expected=idle cycle=%0d", cyc);
            scb.delete();
        end
    endtask

    task automatic one(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int gap);
        wait_idle();
        drop(gap);
        req(f, x, y);
    endtask

    task automatic aux_op(input bit nodiv, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp_res, got;
        int exp_lat, lat;
        bit seen;
        if (nodiv) begin
            exp_res = f[2] ? 32'h0 : model(f, x, y);
            exp_lat = f[2] ? 1 : 33;
        end else begin
            exp_res = model(f, x, y);
            exp_lat = (!f[2] || is_short(f, x, y)) ? 1 : 33;
        end
        @(negedge clk);
        if (nodiv) begin
            n_start = 1'b1; n_op = f; n_a = x; n_b = y;
        end else begin
            f_start = 1'b1; f_op = f; f_a = x; f_b = y;
        end
        lat  = 0;
        seen = 0;
        got  = '0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            n_start = 1'b0;
            f_start = 1'b0;
            if (nodiv ? n_done : f_done) begin
                seen = 1;
                got  = nodiv ? n_result : f_result;
            end
        end
        chk(nodiv ? "nodiv_latency" : "fastmul_latency", 32'(lat), 32'(exp_lat));
        chk(nodiv ? "nodiv_result" : "fastmul_result", got, exp_res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = '0;
        a       = '0;
        b       = '0;
        f_start = 1'b0; f_op = '0; f_a = '0; f_b = '0;
        n_start = 1'b0; n_op = '0; n_a = '0; n_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        one(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        one(3'd1, 32'h8000_0000, 32'h8000_0000, 2);
        one(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        one(3'd2, 32'hFFFF_FFFF, 32'd2, 1);
        one(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        one(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        one(3'd6, 32'hFFFF_FFF9, 32'd2, 3);
        one(3'd4, 32'd7, 32'hFFFF_FFFE, 0);
        one(3'd6, 32'd7, 32'hFFFF_FFFE, 0);
        one(3'd5, 32'd100, 32'd7, 1);
        one(3'd7, 32'd100, 32'd7, 0);
        one(3'd4, 32'd5, 32'd0, 2);
        req(3'd7, 32'd5, 32'd0);
        req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        req(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start pulse in cycle 5 of a running op with new operands must be dropped.
        one(3'd0, 32'd1234, 32'd5678, 2);
        drop(4);
        req(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);

        // Reset asserted in cycle 10 of a running op.
        one(3'd4, 32'd1000, 32'd3, 0);
        drop(9);
        rst_n = 1'b0;
        scb.delete();
        last_result = '0;
        drop(3);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_result", result, 32'd0);
        rst_n = 1'b1;
        drop(1);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] x, y;
            f = 3'($urandom);
            x = rnd32();
            y = rnd32();
            one(f, x, y, $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                drop($urandom_range(1, 25));
                req(3'($urandom), rnd32(), rnd32());
            end
        end
        wait_idle();
        drop(2);

        aux_op(1'b0, 3'd0, 32'd12, 32'd12);
        aux_op(1'b1, 3'd5, 32'd100, 32'd7);
        for (int i = 0; i < 12; i++) begin
            aux_op(1'b0, 3'($urandom), rnd32(), rnd32());
            aux_op(1'b1, 3'($urandom), rnd32(), rnd32());
        end
        drop(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
